// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one shared full-adder stage processes the operands LSB-first,
// one bit per RUN cycle, then reports {cout,s} and signed overflow with a one-cycle done pulse.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  // Handshake: start is accepted only on an edge where ready=1; operands and
  // cin are sampled on that same edge. Results are valid while done=1 and stay
  // held until the next accepted start.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sh, b_sh, s_r, s_shift;
  logic [CW-1:0]    cnt;
  logic             carry, cout_r, ovf_r;
  logic             sum_bit, carry_nx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shared full-adder stage; the new sum bit enters s from the MSB side.
  always_comb begin
    sum_bit  = a_sh[0] ^ b_sh[0] ^ carry;
    carry_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    s_shift  = s_r >> 1;
    s_shift[WIDTH-1] = sum_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      s_r    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= carry_nx;
          s_r   <= s_shift;
          // On the MSB cycle, carry holds carry-into-MSB; the counter stops here.
          if (cnt == LAST) begin
            cout_r <= carry_nx;
            ovf_r  <= carry ^ carry_nx;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ready     = (state == IDLE);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign s         = s_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed scenarios plus random sweeps at
// WIDTH=8 and WIDTH=1, checked against an arithmetic reference model.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       ready8, busy8, done8, cout8, ovf8;
  logic [7:0] s8;
  logic [1:0] st8;

  // 1-bit instance
  logic       start1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       cin1 = 1'b0;
  logic       ready1, busy1, done1, cout1, ovf1;
  logic [0:0] s1;
  logic [1:0] st1;

  serial_add_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8),
    .dbg_state(st8)
  );

  serial_add_ctrl #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .ready(ready1), .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1),
    .dbg_state(st1)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition; overflow when operands share a sign
  // and the truncated sum does not.
  function automatic logic [9:0] ref_add(input int w, input logic [7:0] a, input logic [7:0] b,
                                          input logic c);
    int unsigned mask, sum, res, an, bn, sn;
    logic co, ov;
    mask = (32'd1 << w) - 1;
    sum  = (a & mask) + (b & mask) + c;
    res  = sum & mask;
    co   = ((sum >> w) & 1) != 0;
    an   = (a >> (w - 1)) & 1;
    bn   = (b >> (w - 1)) & 1;
    sn   = (res >> (w - 1)) & 1;
    ov   = (an == bn) && (sn != an);
    return {ov, co, res[7:0]};
  endfunction

  // mode 0: start dropped after acceptance; 1: start held high throughout;
  // 2: start and operands randomised during RUN/DONE.
  task automatic exec8(input logic [7:0] a, input logic [7:0] b, input logic c, input int mode);
    logic [9:0] exp;
    exp = ref_add(8, a, b, c);
    for (int k = 0; k < 20 && !ready8; k++) tick();
    chk("ready8_before_start", ready8, 1'b1);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("busy8_run", {ready8, busy8, done8}, 3'b010);
      if (mode == 0) start8 = 1'b0;
      if (mode == 2) begin
        start8 = 1'($urandom_range(0, 1));
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
      end
      tick();
    end
    chk("done8_flags", {ready8, busy8, done8}, 3'b001);
    chk("result8", {ovf8, cout8, s8}, exp);
    tick();
    chk("ready8_after_done", {ready8, busy8, done8}, 3'b100);
    chk("hold8", {ovf8, cout8, s8}, exp);
    if (mode != 1) start8 = 1'b0;
  endtask

  task automatic exec1(input logic a, input logic b, input logic c);
    logic [9:0] exp;
    exp = ref_add(1, {7'd0, a}, {7'd0, b}, c);
    for (int k = 0; k < 20 && !ready1; k++) tick();
    chk("ready1_before_start", ready1, 1'b1);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    a1 = ~a; b1 = ~b; cin1 = ~c;
    chk("busy1_run", {ready1, busy1, done1}, 3'b010);
    tick();
    chk("done1_flags", {ready1, busy1, done1}, 3'b001);
    chk("result1", {ovf1, cout1, s1}, {exp[9:8], exp[0]});
    tick();
    chk("ready1_after_done", {ready1, busy1, done1}, 3'b100);
  endtask

  initial begin
    // Reset, with start asserted during reset to confirm it is ignored.
    rst = 1'b1; start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    tick(); tick();
    rst = 1'b0; start8 = 1'b0;
    chk("reset_flags8", {ready8, busy8, done8}, 3'b100);
    chk("reset_result8", {ovf8, cout8, s8}, 10'd0);
    chk("reset_flags1", {ready1, busy1, done1}, 3'b100);
    chk("reset_result1", {ovf1, cout1, s1}, 3'd0);

    // Idle with start low holds state.
    repeat (3) tick();
    chk("idle_hold", {ready8, ovf8, cout8, s8}, {1'b1, 10'd0});

    // Directed results.
    exec8(8'h3C, 8'h0F, 1'b0, 0);
    chk("dir_3c_0f", {ovf8, cout8, s8}, {2'b00, 8'h4B});
    exec8(8'hFF, 8'h01, 1'b0, 0);
    chk("dir_ff_01", {ovf8, cout8, s8}, {2'b01, 8'h00});
    exec8(8'h7F, 8'h01, 1'b0, 0);
    chk("dir_7f_01", {ovf8, cout8, s8}, {2'b10, 8'h80});
    exec8(8'h80, 8'h80, 1'b1, 0);
    chk("dir_80_80_c", {ovf8, cout8, s8}, {2'b11, 8'h01});

    // Back-to-back with start held high: one IDLE cycle between done and next RUN.
    for (int i = 0; i < 3; i++)
      exec8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1);
    start8 = 1'b0;
    tick();

    // Reset during the 4th RUN cycle aborts with no done pulse.
    a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (3) tick();
    chk("abort_in_run", busy8, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_flags", {ready8, busy8, done8}, 3'b100);
    chk("abort_result", {ovf8, cout8, s8}, 10'd0);
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_done", done8, 1'b0);
      tick();
    end

    // Operand and start noise during RUN must not affect the result.
    for (int i = 0; i < 5; i++)
      exec8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 2);

    // Random sweeps.
    for (int i = 0; i < 1000; i++)
      exec8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 0);
    for (int i = 0; i < 1000; i++)
      exec1(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
